// File: rtl/register_file_sb.sv
// Register file with a per-register busy scoreboard: two combinational read
// ports with optional write bypass, one write port and one reservation port.

module register_file_sb_rport #(
    parameter int BITS      = 16,
    parameter int ADDR_BITS = 3,
    parameter int DEPTH     = 8,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic [ADDR_BITS-1:0]        addr_i,
    input  logic [DEPTH-1:0][BITS-1:0]  regs_i,
    input  logic [DEPTH-1:0]            busy_i,
    input  logic                        wr_i,
    input  logic [ADDR_BITS-1:0]        waddr_i,
    input  logic [BITS-1:0]             wdata_i,
    output logic [BITS-1:0]             data_o,
    output logic                        ready_o
);
    logic hit;
    assign hit = BYPASS && wr_i && (waddr_i == addr_i);

    always_comb begin
        data_o  = hit ? wdata_i : regs_i[addr_i];
        ready_o = !busy_i[addr_i] || hit;
        // Register 0 masks the bypass too, so it reads 0 even while being written.
        if (ZERO_REG && addr_i == '0) begin
            data_o  = '0;
            ready_o = 1'b1;
        end
    end
endmodule

module register_file_sb #(
    parameter int BITS      = 16,
    parameter int ADDR_BITS = 3,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Write,
    input  logic [ADDR_BITS-1:0] DestAddr,
    input  logic [BITS-1:0]      DestData,
    input  logic [ADDR_BITS-1:0] AddrA,
    input  logic [ADDR_BITS-1:0] AddrB,
    output logic [BITS-1:0]      DataA,
    output logic [BITS-1:0]      DataB,
    output logic                 ReadyA,
    output logic                 ReadyB,
    input  logic                 Reserve,
    input  logic [ADDR_BITS-1:0] ResAddr,
    output logic                 ResGrant,
    output logic [ADDR_BITS:0]   BusyCount
);
    localparam int DEPTH = 2**ADDR_BITS;
    localparam int NPORT = 2;

    logic [DEPTH-1:0][BITS-1:0] regs_q;
    logic [DEPTH-1:0]           busy_q, busy_d;
    logic [ADDR_BITS:0]         cnt_q, cnt_d;
    logic                       wr_eff, wr_store, res_set;

    // Writes are ignored during reset, which also keeps the bypass from leaking data.
    assign wr_eff   = Write && !rst;
    assign wr_store = wr_eff && !(ZERO_REG && DestAddr == '0);
    assign ResGrant = Reserve && (!busy_q[ResAddr] || (wr_eff && DestAddr == ResAddr));
    assign res_set  = ResGrant && !(ZERO_REG && ResAddr == '0);

    always_comb begin
        busy_d = busy_q;
        if (wr_eff)  busy_d[DestAddr] = 1'b0;
        if (res_set) busy_d[ResAddr]  = 1'b1;   // reserve wins over a same-cycle clear
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_d = cnt_d + {{ADDR_BITS{1'b0}}, busy_d[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_store) regs_q[DestAddr] <= DestData;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign BusyCount = cnt_q;

    logic [NPORT-1:0][ADDR_BITS-1:0] rd_addr;
    logic [NPORT-1:0][BITS-1:0]      rd_data;
    logic [NPORT-1:0]                rd_ready;

    assign rd_addr = {AddrB, AddrA};

    genvar p;
    generate
        for (p = 0; p < NPORT; p++) begin : g_rport
            register_file_sb_rport #(
                .BITS(BITS), .ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH),
                .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
            ) u_rport (
                .addr_i  (rd_addr[p]),
                .regs_i  (regs_q),
                .busy_i  (busy_q),
                .wr_i    (wr_eff),
                .waddr_i (DestAddr),
                .wdata_i (DestData),
                .data_o  (rd_data[p]),
                .ready_o (rd_ready[p])
            );
        end
    endgenerate

    assign DataA  = rd_data[0];
    assign DataB  = rd_data[1];
    assign ReadyA = rd_ready[0];
    assign ReadyB = rd_ready[1];
endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed vector table, reset
// corner sequence, then random traffic against an array-based reference model.

module tb_register_file_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        Write;
    logic [2:0]  DestAddr;
    logic [15:0] DestData;
    logic [2:0]  AddrA, AddrB;
    logic [15:0] DataA, DataB;
    logic        ReadyA, ReadyB;
    logic        Reserve;
    logic [2:0]  ResAddr;
    logic        ResGrant;
    logic [3:0]  BusyCount;

    int errors = 0;
    int checks = 0;

    register_file_sb dut (
        .clk(clk), .rst(rst), .Write(Write), .DestAddr(DestAddr), .DestData(DestData),
        .AddrA(AddrA), .AddrB(AddrB), .DataA(DataA), .DataB(DataB),
        .ReadyA(ReadyA), .ReadyB(ReadyB), .Reserve(Reserve), .ResAddr(ResAddr),
        .ResGrant(ResGrant), .BusyCount(BusyCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  da;
        logic [15:0] dd;
        logic [2:0]  aa, ab;
        logic        res;
        logic [2:0]  ra;
        logic [15:0] ea, eb;
        logic        erda, erdb, eg;
        logic [3:0]  ec;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [2:0] da, logic [15:0] dd, logic [2:0] aa,
                                logic [2:0] ab, logic res, logic [2:0] ra, logic [15:0] ea,
                                logic [15:0] eb, logic erda, logic erdb, logic eg, logic [3:0] ec);
        vec_t v;
        v.wr = wr; v.da = da; v.dd = dd; v.aa = aa; v.ab = ab; v.res = res; v.ra = ra;
        v.ea = ea; v.eb = eb; v.erda = erda; v.erdb = erdb; v.eg = eg; v.ec = ec;
        return v;
    endfunction

    task automatic drive(logic wr, logic [2:0] da, logic [15:0] dd, logic [2:0] aa,
                         logic [2:0] ab, logic res, logic [2:0] ra);
        Write = wr; DestAddr = da; DestData = dd; AddrA = aa; AddrB = ab;
        Reserve = res; ResAddr = ra;
    endtask

    // Reference model state
    logic [15:0] m_mem [8];
    bit          m_busy [8];

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [15:0] m_data(logic [2:0] a, logic w, logic [2:0] d, logic [15:0] dd);
        if (a == 0) return 16'h0;
        if (w && d == a) return dd;
        return m_mem[a];
    endfunction

    function automatic logic m_ready(logic [2:0] a, logic w, logic [2:0] d);
        return (a == 0) || !m_busy[a] || (w && d == a);
    endfunction

    vec_t tbl[10];

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset state, and grant follows Reserve while held in reset
        #2;
        chk("rst_cnt", BusyCount, 0);
        chk("rst_dataA", DataA, 0);
        chk("rst_readyA", ReadyA, 1);
        chk("rst_readyB", ReadyB, 1);
        chk("rst_grant0", ResGrant, 0);
        drive(1, 3, 16'hAAAA, 3, 3, 1, 3);
        #1;
        chk("rst_grant1", ResGrant, 1);
        chk("rst_nobypass", DataA, 0);
        @(posedge clk); #1;
        chk("rst_wr_ignored", DataB, 0);
        chk("rst_res_ignored", BusyCount, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        //          wr da dd       aa ab res ra  ea       eb       rdA rdB g  cnt
        tbl[0] = mk(1, 5, 16'h1234, 5, 0, 0, 0, 16'h1234, 16'h0,    1, 1, 0, 0);
        tbl[1] = mk(0, 0, 16'h0,    5, 0, 0, 0, 16'h1234, 16'h0,    1, 1, 0, 0);
        tbl[2] = mk(1, 3, 16'hBEEF, 3, 5, 0, 0, 16'hBEEF, 16'h1234, 1, 1, 0, 0);
        tbl[3] = mk(0, 0, 16'h0,    2, 3, 1, 2, 16'h0,    16'hBEEF, 1, 1, 1, 0);
        tbl[4] = mk(0, 0, 16'h0,    2, 2, 1, 2, 16'h0,    16'h0,    0, 0, 0, 1);
        tbl[5] = mk(1, 2, 16'h0055, 2, 1, 1, 2, 16'h0055, 16'h0,    1, 1, 1, 1);
        tbl[6] = mk(0, 0, 16'h0,    2, 2, 0, 0, 16'h0055, 16'h0055, 0, 0, 0, 1);
        tbl[7] = mk(1, 0, 16'hFFFF, 0, 2, 1, 0, 16'h0,    16'h0055, 1, 0, 1, 1);
        tbl[8] = mk(1, 2, 16'h0AAA, 0, 2, 0, 0, 16'h0,    16'h0AAA, 1, 1, 0, 1);
        tbl[9] = mk(0, 0, 16'h0,    2, 0, 0, 0, 16'h0AAA, 16'h0,    1, 1, 0, 0);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wr, tbl[i].da, tbl[i].dd, tbl[i].aa, tbl[i].ab, tbl[i].res, tbl[i].ra);
            #1;
            chk($sformatf("v%0d_dataA", i), DataA, tbl[i].ea);
            chk($sformatf("v%0d_dataB", i), DataB, tbl[i].eb);
            chk($sformatf("v%0d_readyA", i), ReadyA, tbl[i].erda);
            chk($sformatf("v%0d_readyB", i), ReadyB, tbl[i].erdb);
            chk($sformatf("v%0d_grant", i), ResGrant, tbl[i].eg);
            chk($sformatf("v%0d_cnt", i), BusyCount, tbl[i].ec);
            @(negedge clk);
        end

        // Reserve R1, R4, R7 with R4 holding data, then reset between edges
        drive(1, 4, 16'h7777, 4, 4, 1, 1); @(negedge clk);
        drive(0, 0, 0, 4, 4, 1, 4);        @(negedge clk);
        drive(0, 0, 0, 4, 4, 1, 7);        @(negedge clk);
        drive(0, 0, 0, 4, 4, 0, 0);
        #1;
        chk("seq_cnt3", BusyCount, 3);
        chk("seq_r4_data", DataA, 16'h7777);
        chk("seq_r4_busy", ReadyA, 0);
        #1 rst = 1'b1;
        #1;
        chk("seq_rst_cnt", BusyCount, 0);
        chk("seq_rst_data", DataA, 0);
        chk("seq_rst_ready", ReadyA, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 7, 1, 1, 7);
        #1;
        chk("seq_after_grant", ResGrant, 1);
        @(posedge clk); #1;
        chk("seq_after_cnt", BusyCount, 1);
        chk("seq_after_readyA", ReadyA, 0);
        chk("seq_after_readyB", ReadyB, 1);

        // Random traffic against the reference model; sync model to DUT state
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic r, w, rs, g;
            logic [2:0] d, a, b, ra;
            logic [15:0] dd;
            r  = ($urandom_range(0, 63) == 0);
            w  = $urandom_range(0, 1) == 1;
            rs = $urandom_range(0, 1) == 1;
            d  = 3'($urandom_range(0, 7));
            a  = 3'($urandom_range(0, 7));
            b  = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
            ra = 3'($urandom_range(0, 7));
            dd = 16'($urandom);
            rst = r;
            drive(w, d, dd, a, b, rs, ra);
            if (r) begin
                for (int i = 0; i < 8; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
                w = 1'b0;
            end
            #1;
            g = rs && (!m_busy[ra] || (w && d == ra));
            chk("rnd_dataA", DataA, m_data(a, w, d, dd));
            chk("rnd_dataB", DataB, m_data(b, w, d, dd));
            chk("rnd_readyA", ReadyA, m_ready(a, w, d));
            chk("rnd_readyB", ReadyB, m_ready(b, w, d));
            chk("rnd_grant", ResGrant, g);
            chk("rnd_cnt", BusyCount, m_cnt());
            @(posedge clk);
            if (!r) begin
                if (w && d != 0) m_mem[d] = dd;
                if (w) m_busy[d] = 0;
                if (g && ra != 0) m_busy[ra] = 1;
            end
            @(negedge clk);
        end
        #1;
        chk("rnd_final_cnt", BusyCount, m_cnt());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
